axis_frame_monitor: RTL and testbench
=====================================

AXIS_FRAME_MONITOR -- requirements
Module: axis_frame_monitor

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of monitored AXI-Stream channels (1..8).
REQ-002 The block SHALL have parameter REFCLK_FREQ, default 100_000_000, ACLK cycles per measurement window.
REQ-003 The block SHALL have parameter PWID, default 12, beats-per-line counter width.
REQ-004 The block SHALL have parameter LWID, default 12, lines-per-frame counter width.
REQ-005 The block SHALL have parameter FWID, default 8, frames-per-window counter width.
REQ-006 The block SHALL have port ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports AXIS_TVALID, AXIS_TREADY, AXIS_TUSER and AXIS_TLAST, each input, NCH, one bit per channel.
REQ-009 The block SHALL have port ERR_CLR, input, NCH, per-channel clear of the sticky error flags.
REQ-010 The block SHALL have port PIXEL_CNT, output, NCH*PWID, beats in the last completed line.
REQ-011 The block SHALL have port LINE_CNT, output, NCH*LWID, lines in the last completed frame.
REQ-012 The block SHALL have port FRAME_RATE, output, NCH*FWID, SOFs counted in the last complete window.
REQ-013 The block SHALL have ports ERR_LINE, ERR_FRAME and MEAS_VALID, each output, NCH, per channel.
REQ-014 The block SHALL have port STALL_CNT, output, NCH*32, TVALID && !TREADY cycles counted in the last window.

Function
REQ-015 A beat SHALL be TVALID && TREADY; SOF = beat && TUSER; EOL = beat && TLAST; non-beat cycles are ignored.
REQ-016 Each channel SHALL run an FSM: SYNC -> ACTIVE on SOF; ACTIVE has no exit except reset; all capture in SYNC is suppressed.
REQ-017 In ACTIVE, on EOL, PIXEL_CNT SHALL load the beats of that line including the EOL beat, one cycle after the EOL beat.
REQ-018 In ACTIVE, on SOF, LINE_CNT SHALL load the EOL count of the ended frame one cycle later, and the line counter restarts at 0.
REQ-019 An SOF beat SHALL count as beat 1 of the new line; an SOF+EOL beat gives a 1-beat line and line count 1.
REQ-020 The window counter SHALL pulse every REFCLK_FREQ cycles; on the pulse, FRAME_RATE and STALL_CNT load the window totals and the counters restart.
REQ-021 An SOF coincident with the pulse SHALL be counted in the new window.
REQ-022 All internal counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-023 ERR_LINE SHALL set, sticky, when an EOL line length differs from the previous line of the same frame; the first line of each frame is not compared.
REQ-024 ERR_FRAME SHALL set, sticky, when a completed frame's line count differs from the held LINE_CNT, once MEAS_VALID=1.
REQ-025 ERR_CLR SHALL clear that channel's flags next cycle; a set condition in the same cycle SHALL win.
REQ-026 MEAS_VALID SHALL go 1 on the first LINE_CNT capture after SYNC and stay 1 until reset.
REQ-027 Channels SHALL be fully independent except for the shared window counter.

Reset
REQ-028 With ARESETN=0, all outputs and counters SHALL be 0 and every FSM SHALL be in SYNC, asynchronously.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, each channel waits for a fresh SOF.

Configuration
REQ-030 With AXIS_FRAME_MONITOR_STALL_EN defined, stall counting per REQ-014/020 SHALL be built; when undefined, STALL_CNT SHALL be constant 0 and no stall counters exist.

Structure
REQ-031 Package axis_frame_monitor_pkg SHALL hold the FSM state enum (SYNC, ACTIVE) and the default width constants.
REQ-032 Per-channel logic SHALL be sub-module axis_frame_monitor_ch, instantiated NCH times; the window counter lives in the top.

Verification (REFCLK_FREQ=1000, NCH=2)
REQ-033 Channel 0: 4 lines of 8 beats per frame, continuous -> after the 2nd SOF: PIXEL_CNT=8, LINE_CNT=4, MEAS_VALID=1, no errors.
REQ-034 Channel 0: 3 frames SOF-spaced 300 cycles, the 2nd SOF on the pulse cycle -> FRAME_RATE counts follow REQ-021 exactly; channel 1 is unaffected.
REQ-035 Channel 1: line lengths 8,8,7 -> ERR_LINE=1 after the 7-beat EOL; ERR_CLR pulse -> 0 next cycle; coincident error -> stays 1.
REQ-036 Frames of 4 then 5 lines -> ERR_FRAME=1; TVALID=1 with TREADY=0 for 50 cycles -> STALL_CNT=50 with macro, 0 without.
REQ-037 ARESETN low mid-line, then stream resumes mid-frame -> outputs 0 and no capture until next SOF; a 1-beat SOF+EOL frame -> PIXEL_CNT=1, LINE_CNT=1.

Source files
------------

// File: rtl/axis_frame_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_monitor_pkg
// Description : Shared definitions for the AXI-Stream frame monitor:
//               per-channel FSM state encoding, default counter widths and
//               a helper that sizes the measurement-window counter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_monitor_pkg;

  // Default configuration
  localparam int DEF_NCH         = 2;
  localparam int DEF_REFCLK_FREQ = 100_000_000;
  localparam int DEF_PWID        = 12;
  localparam int DEF_LWID        = 12;
  localparam int DEF_FWID        = 8;
  localparam int STALL_WID       = 32;

  // Per-channel FSM state encoding (explicit width, legacy-compatible constants)
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef enum logic [0:0] {
    SYNC   = ST_SYNC,
    ACTIVE = ST_ACTIVE
  } ch_state_e;

  // Width of a counter that must hold 0 .. cycles-1 (never narrower than 1)
  function automatic int win_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_monitor_ch.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_monitor_ch
// Description : Per-channel AXI-Stream video statistics. Tracks beats per
//               line, lines per frame, SOFs per measurement window and
//               (optionally) stall cycles per window, with sticky line/frame
//               consistency error flags.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               win_pulse       - one-cycle end-of-window strobe (shared)
//               tvalid, tready,
//               tuser, tlast    - monitored stream handshake/sideband
//               err_clr         - clears err_line/err_frame next cycle
//               pixel_cnt       - beats in the last completed line
//               line_cnt        - lines in the last completed frame
//               frame_rate      - SOFs in the last complete window
//               stall_cnt       - valid-without-ready cycles in last window
//               err_line, err_frame, meas_valid - status flags
// Config      : AXIS_FRAME_MONITOR_STALL_EN builds the stall counter;
//               otherwise stall_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_monitor_ch
  import axis_frame_monitor_pkg::*;
#(
  parameter int PWID = DEF_PWID,
  parameter int LWID = DEF_LWID,
  parameter int FWID = DEF_FWID
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 win_pulse,
  input  logic                 tvalid,
  input  logic                 tready,
  input  logic                 tuser,
  input  logic                 tlast,
  input  logic                 err_clr,
  output logic [PWID-1:0]      pixel_cnt,
  output logic [LWID-1:0]      line_cnt,
  output logic [FWID-1:0]      frame_rate,
  output logic [STALL_WID-1:0] stall_cnt,
  output logic                 err_line,
  output logic                 err_frame,
  output logic                 meas_valid
);

  ch_state_e       state;
  logic            beat;
  logic            sof;
  logic            eol;
  logic            active;
  logic [PWID-1:0] pix_acc;
  logic [PWID-1:0] pix_inc;
  logic [PWID-1:0] line_len;
  logic [PWID-1:0] prev_len;
  logic            have_prev;
  logic [LWID-1:0] line_acc;
  logic [LWID-1:0] line_inc;
  logic [FWID-1:0] frm_acc;
  logic            line_err_set;
  logic            frame_err_set;

  assign beat   = tvalid & tready;
  assign sof    = beat & tuser;
  assign eol    = beat & tlast;
  assign active = (state == ACTIVE);

  // Saturating increments
  assign pix_inc  = (&pix_acc)  ? pix_acc  : pix_acc  + 1'b1;
  assign line_inc = (&line_acc) ? line_acc : line_acc + 1'b1;

  // An SOF beat is always beat 1 of a fresh line, whatever preceded it
  assign line_len = sof ? PWID'(1) : pix_inc;

  // First line of a frame has no predecessor, hence the have_prev qualifier
  assign line_err_set  = active & eol & ~sof & have_prev & (line_len != prev_len);
  // Only meaningful once a reference line count has been captured
  assign frame_err_set = active & sof & meas_valid & (line_acc != line_cnt);

  // --------------------------------------------------------------------------
  // Line/frame geometry tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      pix_acc    <= '0;
      prev_len   <= '0;
      have_prev  <= 1'b0;
      line_acc   <= '0;
      pixel_cnt  <= '0;
      line_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          // Lock onto the first SOF: seed the accumulators but publish nothing
          if (sof) begin
            state     <= ACTIVE;
            pix_acc   <= eol ? '0 : PWID'(1);
            line_acc  <= eol ? LWID'(1) : '0;
            prev_len  <= PWID'(1);
            have_prev <= eol;
          end
        end
        ACTIVE: begin
          if (beat) begin
            if (eol) begin
              pixel_cnt <= line_len;
              prev_len  <= line_len;
              pix_acc   <= '0;
            end else begin
              pix_acc   <= sof ? PWID'(1) : pix_inc;
            end

            if (sof) begin
              line_cnt   <= line_acc;
              meas_valid <= 1'b1;
              line_acc   <= eol ? LWID'(1) : '0;
              have_prev  <= eol;
            end else if (eol) begin
              line_acc   <= line_inc;
              have_prev  <= 1'b1;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a set condition overrides a simultaneous clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_line  <= line_err_set  | (err_line  & ~err_clr);
      err_frame <= frame_err_set | (err_frame & ~err_clr);
    end
  end

  // --------------------------------------------------------------------------
  // SOFs per window; an SOF on the pulse cycle opens the new window
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_acc    <= '0;
      frame_rate <= '0;
    end else if (win_pulse) begin
      frame_rate <= frm_acc;
      frm_acc    <= sof ? FWID'(1) : '0;
    end else if (sof && !(&frm_acc)) begin
      frm_acc    <= frm_acc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stall cycles per window (same window alignment as the SOF count)
  // --------------------------------------------------------------------------
`ifdef AXIS_FRAME_MONITOR_STALL_EN
  logic [STALL_WID-1:0] stall_acc;
  logic                 stall;

  assign stall = tvalid & ~tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_acc <= '0;
      stall_cnt <= '0;
    end else if (win_pulse) begin
      stall_cnt <= stall_acc;
      stall_acc <= stall ? STALL_WID'(1) : '0;
    end else if (stall && !(&stall_acc)) begin
      stall_acc <= stall_acc + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/axis_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_monitor
// Description : Multi-channel AXI-Stream video frame monitor. Owns the shared
//               measurement-window timer and instantiates one
//               axis_frame_monitor_ch per monitored channel.
// Ports       : ACLK, ARESETN   - clock, asynchronous active-low reset
//               AXIS_TVALID/TREADY/TUSER/TLAST [NCH] - monitored streams
//               ERR_CLR [NCH]   - per-channel sticky error clear
//               PIXEL_CNT  [NCH*PWID] - beats in last completed line
//               LINE_CNT   [NCH*LWID] - lines in last completed frame
//               FRAME_RATE [NCH*FWID] - SOFs in last complete window
//               STALL_CNT  [NCH*32]   - stall cycles in last window
//               ERR_LINE, ERR_FRAME, MEAS_VALID [NCH] - status flags
// Config      : AXIS_FRAME_MONITOR_STALL_EN enables stall counting.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_monitor
  import axis_frame_monitor_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int REFCLK_FREQ = DEF_REFCLK_FREQ,
  parameter int PWID        = DEF_PWID,
  parameter int LWID        = DEF_LWID,
  parameter int FWID        = DEF_FWID
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NCH-1:0]           AXIS_TVALID,
  input  logic [NCH-1:0]           AXIS_TREADY,
  input  logic [NCH-1:0]           AXIS_TUSER,
  input  logic [NCH-1:0]           AXIS_TLAST,
  input  logic [NCH-1:0]           ERR_CLR,
  output logic [NCH*PWID-1:0]      PIXEL_CNT,
  output logic [NCH*LWID-1:0]      LINE_CNT,
  output logic [NCH*FWID-1:0]      FRAME_RATE,
  output logic [NCH-1:0]           ERR_LINE,
  output logic [NCH-1:0]           ERR_FRAME,
  output logic [NCH-1:0]           MEAS_VALID,
  output logic [NCH*STALL_WID-1:0] STALL_CNT
);

  localparam int             WCW      = win_cnt_width(REFCLK_FREQ);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(REFCLK_FREQ - 1);

  logic [WCW-1:0] win_cnt;
  logic           win_pulse;

  // Pulse on the last cycle of each REFCLK_FREQ-cycle window
  assign win_pulse = (win_cnt == WIN_LAST);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_pulse ? '0 : win_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      axis_frame_monitor_ch #(
        .PWID (PWID),
        .LWID (LWID),
        .FWID (FWID)
      ) u_ch (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .win_pulse  (win_pulse),
        .tvalid     (AXIS_TVALID[i]),
        .tready     (AXIS_TREADY[i]),
        .tuser      (AXIS_TUSER[i]),
        .tlast      (AXIS_TLAST[i]),
        .err_clr    (ERR_CLR[i]),
        .pixel_cnt  (PIXEL_CNT[i*PWID +: PWID]),
        .line_cnt   (LINE_CNT[i*LWID +: LWID]),
        .frame_rate (FRAME_RATE[i*FWID +: FWID]),
        .stall_cnt  (STALL_CNT[i*STALL_WID +: STALL_WID]),
        .err_line   (ERR_LINE[i]),
        .err_frame  (ERR_FRAME[i]),
        .meas_valid (MEAS_VALID[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axis_frame_monitor
// Description : Scoreboard bench for axis_frame_monitor (NCH=2,
//               REFCLK_FREQ=1000). Stimulus pushes hand-computed expected
//               values with a due cycle; a monitor on the falling edge pops
//               and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_monitor;

  localparam int NCH    = 2;
  localparam int REFCLK = 1000;
  localparam int PWID   = 12;
  localparam int LWID   = 12;
  localparam int FWID   = 8;

  localparam int S_PIX = 0, S_LINE = 1, S_FR = 2, S_EL = 3, S_EF = 4, S_MV = 5, S_ST = 6;

`ifdef AXIS_FRAME_MONITOR_STALL_EN
  localparam longint EXP_STALL = 50;
`else
  localparam longint EXP_STALL = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] tvalid  = '0;
  logic [NCH-1:0] tready  = '0;
  logic [NCH-1:0] tuser   = '0;
  logic [NCH-1:0] tlast   = '0;
  logic [NCH-1:0] err_clr = '0;

  logic [NCH*PWID-1:0] pixel_cnt;
  logic [NCH*LWID-1:0] line_cnt;
  logic [NCH*FWID-1:0] frame_rate;
  logic [NCH-1:0]      err_line;
  logic [NCH-1:0]      err_frame;
  logic [NCH-1:0]      meas_valid;
  logic [NCH*32-1:0]   stall_cnt;

  axis_frame_monitor #(
    .NCH(NCH), .REFCLK_FREQ(REFCLK), .PWID(PWID), .LWID(LWID), .FWID(FWID)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .AXIS_TVALID(tvalid), .AXIS_TREADY(tready), .AXIS_TUSER(tuser), .AXIS_TLAST(tlast),
    .ERR_CLR(err_clr),
    .PIXEL_CNT(pixel_cnt), .LINE_CNT(line_cnt), .FRAME_RATE(frame_rate),
    .ERR_LINE(err_line), .ERR_FRAME(err_frame), .MEAS_VALID(meas_valid),
    .STALL_CNT(stall_cnt)
  );

  always #5 clk = ~clk;

  // tick: free-running edge count for scoreboard timing
  // cyc : edges since reset release, aligned with the DUT window timer
  int tick = 0;
  int cyc  = 0;
  always @(posedge clk) tick <= tick + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int     due;
    int     sel;
    int     ch;
    longint exp;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   flush  = 1'b0;

  function automatic longint get_out(input int sel, input int ch);
    case (sel)
      S_PIX:   return longint'(pixel_cnt[ch*PWID +: PWID]);
      S_LINE:  return longint'(line_cnt[ch*LWID +: LWID]);
      S_FR:    return longint'(frame_rate[ch*FWID +: FWID]);
      S_EL:    return longint'(err_line[ch]);
      S_EF:    return longint'(err_frame[ch]);
      S_MV:    return longint'(meas_valid[ch]);
      default: return longint'(stall_cnt[ch*32 +: 32]);
    endcase
  endfunction

  // dly=0: checked at the coming falling edge; dly=1: after the next beat
  task automatic expect_out(input int dly, input int sel, input int ch,
                            input longint exp, input string name);
    exp_t e;
    e.due  = tick + dly;
    e.sel  = sel;
    e.ch   = ch;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    int     i;
    longint act;
    i = 0;
    while (i < sb.size()) begin
      if (flush || sb[i].due < tick) begin
        checks++;
        errors++;
        $display("FAIL %s ch%0d: never compared (due %0d, now %0d)",
                 sb[i].name, sb[i].ch, sb[i].due, tick);
        sb.delete(i);
      end else if (sb[i].due == tick) begin
        act = get_out(sb[i].sel, sb[i].ch);
        checks++;
        if (act != sb[i].exp) begin
          errors++;
          $display("FAIL %s ch%0d @tick %0d: got %0d expected %0d",
                   sb[i].name, sb[i].ch, tick, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] r,
                       input logic [NCH-1:0] u, input logic [NCH-1:0] l,
                       input logic [NCH-1:0] c);
    tvalid  = v;
    tready  = r;
    tuser   = u;
    tlast   = l;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, '0, '0, '0, '0);
  endtask

  task automatic beat(input int ch, input bit u, input bit l, input bit c);
    logic [NCH-1:0] m;
    m     = '0;
    m[ch] = 1'b1;
    drive(m, m, u ? m : '0, l ? m : '0, c ? m : '0);
  endtask

  task automatic clr(input int ch);
    logic [NCH-1:0] m;
    m     = '0;
    m[ch] = 1'b1;
    drive('0, '0, '0, '0, m);
  endtask

  // exp_el < 0 means "do not check err_line"
  task automatic send_line(input int ch, input int len, input bit sof, input bit chk,
                           input int exp_el, input bit clr_eol);
    for (int b = 0; b < len; b++) begin
      if (b == len - 1) begin
        if (chk)         expect_out(1, S_PIX, ch, longint'(len), "pixel_cnt");
        if (exp_el >= 0) expect_out(1, S_EL, ch, longint'(exp_el), "err_line");
      end
      beat(ch, sof && (b == 0), b == len - 1, clr_eol && (b == len - 1));
    end
  endtask

  task automatic send_frame(input int ch, input int nl, input int len);
    for (int n = 0; n < nl; n++) send_line(ch, len, n == 0, 1'b1, -1, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) idle(1);
  endtask

  task automatic expect_all_zero();
    for (int c = 0; c < NCH; c++) begin
      expect_out(0, S_PIX,  c, 0, "rst_pixel_cnt");
      expect_out(0, S_LINE, c, 0, "rst_line_cnt");
      expect_out(0, S_FR,   c, 0, "rst_frame_rate");
      expect_out(0, S_EL,   c, 0, "rst_err_line");
      expect_out(0, S_EF,   c, 0, "rst_err_frame");
      expect_out(0, S_MV,   c, 0, "rst_meas_valid");
      expect_out(0, S_ST,   c, 0, "rst_stall_cnt");
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    expect_all_zero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;                        // cyc == 0, first SOF lands on edge 1

    // Continuous 4x8 frames on channel 0
    send_frame(0, 4, 8);
    expect_out(0, S_MV, 0, 0, "mv_before_capture");
    expect_out(1, S_LINE, 0, 4, "line_cnt_2nd_sof");
    expect_out(1, S_MV,   0, 1, "mv_2nd_sof");
    expect_out(1, S_EL,   0, 0, "err_line_clean");
    expect_out(1, S_EF,   0, 0, "err_frame_clean");
    send_frame(0, 4, 8);

    // SOFs at edges 700, 1000 (pulse edge), 1300
    wait_cyc(699);
    expect_out(1, S_LINE, 0, 4, "line_cnt_sof700");
    send_frame(0, 4, 8);
    wait_cyc(999);
    expect_out(0, S_FR, 0, 0, "frame_rate_before_pulse");
    expect_out(1, S_FR, 0, 3, "frame_rate_win1");
    expect_out(1, S_FR, 1, 0, "frame_rate_ch1_win1");
    expect_out(1, S_EF, 0, 0, "err_frame_sof1000");
    send_frame(0, 4, 8);
    wait_cyc(1299);
    send_frame(0, 4, 8);
    wait_cyc(1999);
    expect_out(1, S_FR, 0, 2, "frame_rate_win2");
    expect_out(1, S_FR, 1, 0, "frame_rate_ch1_win2");
    expect_out(1, S_ST, 0, 0, "stall_win2");
    expect_out(1, S_MV, 1, 0, "mv_ch1_untouched");
    idle(1);

    // Channel 1: line lengths 8,8,7 then error clear behaviour
    send_line(1, 8, 1'b1, 1'b1, 0, 1'b0);
    send_line(1, 8, 1'b0, 1'b1, 0, 1'b0);
    send_line(1, 7, 1'b0, 1'b1, 1, 1'b0);
    expect_out(0, S_MV, 1, 0, "mv_ch1_first_frame");
    expect_out(0, S_EL, 1, 1, "err_line_sticky");
    expect_out(1, S_EL, 1, 0, "err_line_cleared");
    clr(1);
    send_line(1, 8, 1'b0, 1'b1, 1, 1'b1); // mismatch coincident with clear
    expect_out(1, S_EL, 1, 0, "err_line_cleared2");
    clr(1);

    // Channel 1: frames of 4 then 5 lines
    expect_out(1, S_LINE, 1, 4, "line_cnt_ch1_first");
    expect_out(1, S_MV,   1, 1, "mv_ch1_first");
    expect_out(1, S_EF,   1, 0, "err_frame_first");
    send_frame(1, 4, 4);
    expect_out(1, S_LINE, 1, 4, "line_cnt_4line");
    expect_out(1, S_EF,   1, 0, "err_frame_4v4");
    send_frame(1, 5, 4);
    expect_out(1, S_LINE, 1, 5, "line_cnt_5line");
    expect_out(1, S_EF,   1, 1, "err_frame_5v4");
    expect_out(1, S_EL,   1, 0, "err_line_uniform");
    beat(1, 1'b1, 1'b0, 1'b0);
    expect_out(1, S_EF, 1, 0, "err_frame_cleared");
    clr(1);

    // Channel 0: 50 stall cycles in window 3
    wait_cyc(2199);
    for (int k = 0; k < 50; k++) drive(2'b01, 2'b00, '0, '0, '0);
    wait_cyc(2999);
    expect_out(1, S_ST, 0, EXP_STALL, "stall_cnt_win3");
    expect_out(1, S_ST, 1, 0, "stall_cnt_ch1_win3");
    expect_out(1, S_FR, 1, 4, "frame_rate_ch1_win3");
    expect_out(1, S_FR, 0, 0, "frame_rate_ch0_win3");
    idle(1);

    // Reset mid-line, then resume mid-frame
    beat(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) beat(0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_all_zero();
    idle(2);
    rst_n = 1'b1;
    send_line(0, 5, 1'b0, 1'b0, -1, 1'b0);
    send_line(0, 8, 1'b0, 1'b0, -1, 1'b0);
    expect_out(0, S_PIX,  0, 0, "pix_no_capture_sync");
    expect_out(0, S_LINE, 0, 0, "line_no_capture_sync");
    expect_out(0, S_MV,   0, 0, "mv_no_capture_sync");
    beat(0, 1'b1, 1'b1, 1'b0);
    expect_out(1, S_PIX,  0, 1, "pix_one_beat_frame");
    expect_out(1, S_LINE, 0, 1, "line_one_beat_frame");
    expect_out(1, S_MV,   0, 1, "mv_after_resync");
    expect_out(1, S_EL,   0, 0, "err_line_one_beat");
    expect_out(1, S_EF,   0, 0, "err_frame_one_beat");
    beat(0, 1'b1, 1'b1, 1'b0);
    idle(3);

    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
